// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Resolves conditional branches in the ID stage. It decides whether the
// branch comparator operands are available yet, stalls the front end while
// they are not, selects the comparator operand sources, and redirects and
// flushes on a taken branch.
//
// Optional feature: define BRANCH_PERF_EN to add 32-bit performance counters
// for resolves, taken resolves and stall cycles. Without the macro those
// ports and counters are absent.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_sb_type                      ID holds a conditional branch
//   id_rs1, id_rs2                  branch source registers
//   ex_reg_write/ex_mem_read/ex_rd  EX-stage producer
//   mem_reg_write/mem_mem_read/mem_rd  MEM-stage producer
//   wb_reg_write/wb_rd              WB-stage producer
//   ext_stall                       global pipeline freeze
//   branch_in                       comparator result for current operands
//   fwd_a_sel, fwd_b_sel            00 regfile, 01 MEM ALU result, 10 WB data
//   stall                           hold PC and IF/ID, bubble ID/EX
//   branch_taken                    redirect PC
//   flush_if                        zero IF/ID
//   perf_branches/taken/stalls      (BRANCH_PERF_EN only) event counters
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | no branch pending; a hazard-free branch resolves here at once
// HOLD  | waiting on an EX-stage load; cnt counts remaining wait cycles
// RESOLVE | operands now forwardable; branch resolves this cycle
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
    parameter int XLEN_REGS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_sb_type,
    input  logic [XLEN_REGS-1:0] id_rs1,
    input  logic [XLEN_REGS-1:0] id_rs2,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic [XLEN_REGS-1:0] ex_rd,
    input  logic                 mem_reg_write,
    input  logic                 mem_mem_read,
    input  logic [XLEN_REGS-1:0] mem_rd,
    input  logic                 wb_reg_write,
    input  logic [XLEN_REGS-1:0] wb_rd,
    input  logic                 ext_stall,
    input  logic                 branch_in,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic                 stall,
    output logic                 branch_taken,
    output logic                 flush_if
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0]          perf_branches,
    output logic [31:0]          perf_taken,
    output logic [31:0]          perf_stalls
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [1:0] need_a, need_b, need;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_int;
    logic       resolve;

    function automatic logic reg_match(input logic [XLEN_REGS-1:0] f_x,
                                       input logic [XLEN_REGS-1:0] f_rd);
        return (f_rd != '0) && (f_rd == f_x);
    endfunction

    // Wait cycles an operand still needs before it can be forwarded:
    // an EX load needs two (value appears in WB), an EX ALU op or a MEM load
    // needs one.
    function automatic logic [1:0] need_of(input logic [XLEN_REGS-1:0] f_x,
                                           input logic                 f_ex_rw,
                                           input logic                 f_ex_mr,
                                           input logic [XLEN_REGS-1:0] f_ex_rd,
                                           input logic                 f_mem_mr,
                                           input logic [XLEN_REGS-1:0] f_mem_rd);
        if (f_ex_mr && reg_match(f_x, f_ex_rd))
            return 2'd2;
        else if (f_ex_rw && reg_match(f_x, f_ex_rd))
            return 2'd1;
        else if (f_mem_mr && reg_match(f_x, f_mem_rd))
            return 2'd1;
        else
            return 2'd0;
    endfunction

    // The younger producer (MEM ALU result) wins over WB.
    function automatic logic [1:0] fwd_of(input logic [XLEN_REGS-1:0] f_x,
                                          input logic                 f_mem_rw,
                                          input logic                 f_mem_mr,
                                          input logic [XLEN_REGS-1:0] f_mem_rd,
                                          input logic                 f_wb_rw,
                                          input logic [XLEN_REGS-1:0] f_wb_rd);
        if (f_mem_rw && !f_mem_mr && reg_match(f_x, f_mem_rd))
            return 2'b01;
        else if (f_wb_rw && reg_match(f_x, f_wb_rd))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        need_a = need_of(id_rs1, ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd);
        need_b = need_of(id_rs2, ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd);
        need   = (need_a > need_b) ? need_a : need_b;
        fwd_a  = fwd_of(id_rs1, mem_reg_write, mem_mem_read, mem_rd, wb_reg_write, wb_rd);
        fwd_b  = fwd_of(id_rs2, mem_reg_write, mem_mem_read, mem_rd, wb_reg_write, wb_rd);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_int = 1'b0;
        resolve   = 1'b0;

        if (!id_sb_type) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (need != 2'd0) begin
                        stall_int = 1'b1;
                        cnt_d     = need - 2'd1;
                        state_d   = (need == 2'd2) ? HOLD : RESOLVE;
                    end else begin
                        resolve = 1'b1;
                    end
                end
                HOLD: begin
                    stall_int = 1'b1;
                    if (cnt_q == 2'd1) begin
                        state_d = RESOLVE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                RESOLVE: begin
                    resolve = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end

        // A frozen pipeline must not advance the FSM.
        if (ext_stall) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by rst_n so an asserted reset silences them at once,
    // even while ID still presents a hazarding branch.
    always_comb begin
        stall        = rst_n & stall_int;
        branch_taken = rst_n & resolve & ~ext_stall & branch_in;
        flush_if     = rst_n & resolve & ~ext_stall & branch_in;
        fwd_a_sel    = (rst_n && id_sb_type) ? fwd_a : 2'b00;
        fwd_b_sel    = (rst_n && id_sb_type) ? fwd_b : 2'b00;
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_taken_q,    perf_taken_d;
    logic [31:0] perf_stalls_q,   perf_stalls_d;

    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_taken_d    = perf_taken_q;
        perf_stalls_d   = perf_stalls_q;
        if (resolve && !ext_stall) begin
            perf_branches_d = perf_branches_q + 32'd1;
            if (branch_in)
                perf_taken_d = perf_taken_q + 32'd1;
        end
        if (stall_int && !ext_stall)
            perf_stalls_d = perf_stalls_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q <= 32'd0;
            perf_taken_q    <= 32'd0;
            perf_stalls_q   <= 32'd0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_taken_q    <= perf_taken_d;
            perf_stalls_q   <= perf_stalls_d;
        end
    end

    assign perf_branches = perf_branches_q;
    assign perf_taken    = perf_taken_q;
    assign perf_stalls   = perf_stalls_q;
`endif

endmodule
